// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Command sequencer between the UART byte stream and the register bus.
// Parses host frames ('W' addr data, 'R' addr, 'B' addr N), performs one
// register bus transfer at a time and returns one response byte per transfer
// to the UART transmitter with valid/ready flow control.
//
// Ports:
//   xipMCLK, xinRESET        clock, synchronous active-low reset
//   rx_data, rx_valid        received byte strobe
//   tx_data, tx_valid,
//   tx_ready                 response byte stream (valid/ready)
//   rb_addr, rb_wdata,
//   rb_we, rb_re,
//   rb_rdata, rb_ack         register bus master side
//   busy                     high whenever the sequencer is not idle
//   err_to, err_ovf, err_clr sticky bus-timeout / RX-drop flags and their clear
module uart_cmd_ctrl #(
    parameter int unsigned BUS_TO   = 255,
    parameter int unsigned FRAME_TO = 65535
) (
    input  logic       xipMCLK,
    input  logic       xinRESET,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] rb_addr,
    output logic [7:0] rb_wdata,
    output logic       rb_we,
    output logic       rb_re,
    input  logic [7:0] rb_rdata,
    input  logic       rb_ack,
    output logic       busy,
    output logic       err_to,
    output logic       err_ovf,
    input  logic       err_clr
);

    localparam logic [7:0]  OPC_WR     = 8'h57;
    localparam logic [7:0]  OPC_RD     = 8'h52;
    localparam logic [7:0]  OPC_BURST  = 8'h42;
    localparam logic [7:0]  RSP_ACK    = 8'h06;
    localparam logic [7:0]  RSP_TO     = 8'hFF;
    localparam logic [7:0]  BUS_TO_LD  = 8'(BUS_TO - 1);
    localparam logic [15:0] FRAME_TO_LD = 16'(FRAME_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_ARG,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_TX_SEND
    } state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BURST
    } op_t;

    state_t      state_r,     state_s;
    op_t         op_r,        op_s;
    logic [7:0]  rem_r,       rem_s;        // burst reads still to do after the current one
    logic [7:0]  bus_cnt_r,   bus_cnt_s;    // request cycles left before timeout
    logic [15:0] frame_cnt_r, frame_cnt_s;  // idle cycles left inside a frame
    logic [7:0]  tx_data_r,   tx_data_s;
    logic        tx_valid_r,  tx_valid_s;
    logic [7:0]  rb_addr_r,   rb_addr_s;
    logic [7:0]  rb_wdata_r,  rb_wdata_s;
    logic        rb_we_r,     rb_we_s;
    logic        rb_re_r,     rb_re_s;
    logic        busy_r;
    logic        err_to_r,    err_to_s;
    logic        err_ovf_r,   err_ovf_s;
    logic        to_set_s;
    logic        ovf_set_s;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        rem_s       = rem_r;
        bus_cnt_s   = bus_cnt_r;
        frame_cnt_s = frame_cnt_r;
        tx_data_s   = tx_data_r;
        tx_valid_s  = tx_valid_r;
        rb_addr_s   = rb_addr_r;
        rb_wdata_s  = rb_wdata_r;
        rb_we_s     = rb_we_r;
        rb_re_s     = rb_re_r;
        to_set_s    = 1'b0;
        ovf_set_s   = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (rx_valid) begin
                    frame_cnt_s = FRAME_TO_LD;
                    rem_s       = 8'd0;
                    if (rx_data == OPC_WR) begin
                        op_s    = OP_WR;
                        state_s = S_GET_ADDR;
                    end else if (rx_data == OPC_RD) begin
                        op_s    = OP_RD;
                        state_s = S_GET_ADDR;
                    end else if (rx_data == OPC_BURST) begin
                        op_s    = OP_BURST;
                        state_s = S_GET_ADDR;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    rb_addr_s   = rx_data;
                    frame_cnt_s = FRAME_TO_LD;
                    if (op_r == OP_RD) begin
                        state_s = S_BUS_REQ;
                    end else begin
                        state_s = S_GET_ARG;
                    end
                end else if (frame_cnt_r == 16'd0) begin
                    state_s = S_IDLE;
                end else begin
                    frame_cnt_s = frame_cnt_r - 16'd1;
                end
            end
            S_GET_ARG: begin
                if (rx_valid) begin
                    frame_cnt_s = FRAME_TO_LD;
                    if (op_r == OP_WR) begin
                        rb_wdata_s = rx_data;
                        state_s    = S_BUS_REQ;
                    end else if (rx_data == 8'd0) begin
                        // zero-length burst: nothing to do, nothing to answer
                        state_s = S_IDLE;
                    end else begin
                        rem_s   = rx_data - 8'd1;
                        state_s = S_BUS_REQ;
                    end
                end else if (frame_cnt_r == 16'd0) begin
                    state_s = S_IDLE;
                end else begin
                    frame_cnt_s = frame_cnt_r - 16'd1;
                end
            end
            S_BUS_REQ: begin
                bus_cnt_s = BUS_TO_LD;
                state_s   = S_BUS_WAIT;
                if (op_r == OP_WR) begin
                    rb_we_s = 1'b1;
                end else begin
                    rb_re_s = 1'b1;
                end
            end
            S_BUS_WAIT: begin
                // ack wins over a timeout expiring in the same cycle
                if (rb_ack) begin
                    rb_we_s    = 1'b0;
                    rb_re_s    = 1'b0;
                    tx_valid_s = 1'b1;
                    tx_data_s  = (op_r == OP_WR) ? RSP_ACK : rb_rdata;
                    state_s    = S_TX_SEND;
                end else if (bus_cnt_r == 8'd0) begin
                    rb_we_s    = 1'b0;
                    rb_re_s    = 1'b0;
                    tx_valid_s = 1'b1;
                    tx_data_s  = RSP_TO;
                    to_set_s   = 1'b1;
                    state_s    = S_TX_SEND;
                end else begin
                    bus_cnt_s = bus_cnt_r - 8'd1;
                end
            end
            S_TX_SEND: begin
                if (tx_ready) begin
                    tx_valid_s = 1'b0;
                    if (rem_r != 8'd0) begin
                        rb_addr_s = rb_addr_r + 8'd1;   // wraps 0xFF -> 0x00
                        rem_s     = rem_r - 8'd1;
                        state_s   = S_BUS_REQ;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_TX_SEND;
                end
            end
            default: begin
                state_s    = S_IDLE;
                tx_valid_s = 1'b0;
                rb_we_s    = 1'b0;
                rb_re_s    = 1'b0;
            end
        endcase

        // bytes arriving while a transfer is in flight are never queued
        if (rx_valid && ((state_r == S_BUS_REQ) || (state_r == S_BUS_WAIT) ||
                         (state_r == S_TX_SEND))) begin
            ovf_set_s = 1'b1;
        end else begin
            ovf_set_s = 1'b0;
        end

        if (to_set_s) begin
            err_to_s = 1'b1;
        end else if (err_clr) begin
            err_to_s = 1'b0;
        end else begin
            err_to_s = err_to_r;
        end

        if (ovf_set_s) begin
            err_ovf_s = 1'b1;
        end else if (err_clr) begin
            err_ovf_s = 1'b0;
        end else begin
            err_ovf_s = err_ovf_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge xipMCLK) begin
        if (!xinRESET) begin
            state_r     <= S_IDLE;
            op_r        <= OP_RD;
            rem_r       <= 8'd0;
            bus_cnt_r   <= 8'd0;
            frame_cnt_r <= 16'd0;
            tx_data_r   <= 8'd0;
            tx_valid_r  <= 1'b0;
            rb_addr_r   <= 8'd0;
            rb_wdata_r  <= 8'd0;
            rb_we_r     <= 1'b0;
            rb_re_r     <= 1'b0;
            busy_r      <= 1'b0;
            err_to_r    <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            rem_r       <= rem_s;
            bus_cnt_r   <= bus_cnt_s;
            frame_cnt_r <= frame_cnt_s;
            tx_data_r   <= tx_data_s;
            tx_valid_r  <= tx_valid_s;
            rb_addr_r   <= rb_addr_s;
            rb_wdata_r  <= rb_wdata_s;
            rb_we_r     <= rb_we_s;
            rb_re_r     <= rb_re_s;
            busy_r      <= (state_s != S_IDLE);
            err_to_r    <= err_to_s;
            err_ovf_r   <= err_ovf_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign rb_addr  = rb_addr_r;
    assign rb_wdata = rb_wdata_r;
    assign rb_we    = rb_we_r;
    assign rb_re    = rb_re_r;
    assign busy     = busy_r;
    assign err_to   = err_to_r;
    assign err_ovf  = err_ovf_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (BUS_TO = 8, FRAME_TO = 20).
// A behavioural register slave with programmable ack delay logs every bus
// transfer; a transmitter model logs every handshaken response byte.
module tb_uart_cmd_ctrl;

    localparam int BUS_TO   = 8;
    localparam int FRAME_TO = 20;

    logic       clk = 1'b0;
    logic       xinRESET;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rb_addr;
    logic [7:0] rb_wdata;
    logic       rb_we;
    logic       rb_re;
    logic [7:0] rb_rdata;
    logic       rb_ack;
    logic       busy;
    logic       err_to;
    logic       err_ovf;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    // slave model state and transfer log
    logic [7:0] mem [256];
    int         ack_delay = 1;   // ack in the Nth request cycle, 0 = never
    logic       req_prev = 1'b0;
    int         cur_len;
    logic [7:0] cur_addr;
    logic       cur_we;
    logic [7:0] cur_wd;
    logic [7:0] log_addr [64];
    logic       log_we [64];
    logic [7:0] log_wd [64];
    int         log_len [64];
    int         n_log = 0;

    // transmitter model
    logic       stall = 1'b0;
    logic [7:0] tx_log [64];
    int         n_tx = 0;

    int base_log;
    int base_tx;
    int n;

    uart_cmd_ctrl #(.BUS_TO(BUS_TO), .FRAME_TO(FRAME_TO)) dut (
        .xipMCLK (clk),
        .xinRESET(xinRESET),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rb_addr (rb_addr),
        .rb_wdata(rb_wdata),
        .rb_we   (rb_we),
        .rb_re   (rb_re),
        .rb_rdata(rb_rdata),
        .rb_ack  (rb_ack),
        .busy    (busy),
        .err_to  (err_to),
        .err_ovf (err_ovf),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, {31'd0, busy}, 32'd0);
    endtask

    // Register slave: counts request cycles, acks after ack_delay, logs transfers.
    initial begin
        rb_ack   = 1'b0;
        rb_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rb_re || rb_we) begin
                if (!req_prev) begin
                    cur_len  = 0;
                    cur_addr = rb_addr;
                    cur_we   = rb_we;
                    cur_wd   = rb_wdata;
                end
                cur_len++;
                if (ack_delay != 0 && cur_len == ack_delay) begin
                    rb_ack   = 1'b1;
                    rb_rdata = mem[rb_addr];
                    if (rb_we) mem[rb_addr] = rb_wdata;
                end else begin
                    rb_ack   = 1'b0;
                    rb_rdata = 8'hEE;
                end
                req_prev = 1'b1;
            end else begin
                rb_ack = 1'b0;
                if (req_prev && n_log < 64) begin
                    log_addr[n_log] = cur_addr;
                    log_we[n_log]   = cur_we;
                    log_wd[n_log]   = cur_wd;
                    log_len[n_log]  = cur_len;
                    n_log++;
                end
                req_prev = 1'b0;
            end
        end
    end

    // Transmitter: ready unless stalled, logs each accepted byte.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready = !stall;
            if (tx_valid && tx_ready && n_tx < 64) begin
                tx_log[n_tx] = tx_data;
                n_tx++;
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
        mem[8'h80] = 8'h5A;
        mem[8'h81] = 8'h9C;
        mem[8'h86] = 8'h77;
        mem[8'h91] = 8'h33;
        mem[8'h92] = 8'hC4;
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h44;
        xinRESET = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check_val("rst_outs", {25'd0, tx_valid, rb_we, rb_re, busy, err_to, err_ovf, 1'b0},
                  32'd0);
        check_val("rst_addr_wd", {16'd0, rb_addr, rb_wdata}, 32'h0000);
        xinRESET = 1'b1;

        // single read, slave acks in the 3rd request cycle
        ack_delay = 3;
        send_byte(8'h52);
        check_val("rd_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h80);
        check_val("rd_req_not_yet", {31'd0, rb_re}, 32'd0);
        @(negedge clk);
        check_val("rd_req_rise", {30'd0, rb_re, rb_we}, 32'd2);
        wait_idle("rd_idle", 40);
        check_val("rd_nlog", n_log, 1);
        check_val("rd_addr", {24'd0, log_addr[0]}, 32'h80);
        check_val("rd_len", log_len[0], 3);
        check_val("rd_ntx", n_tx, 1);
        check_val("rd_data", {24'd0, tx_log[0]}, 32'h5A);

        // single write
        ack_delay = 2;
        send_byte(8'h57);
        send_byte(8'h90);
        send_byte(8'h0A);
        wait_idle("wr_idle", 40);
        check_val("wr_xfer", {23'd0, log_we[1], log_addr[1], log_wd[1]}, 32'h1_90_0A);
        check_val("wr_rsp", {24'd0, tx_log[1]}, 32'h06);

        // burst of 3 with a 10-cycle transmitter stall on the second byte
        ack_delay = 1;
        send_byte(8'h42);
        send_byte(8'h90);
        send_byte(8'h03);
        n = 0;
        while (n_tx < 3 && n < 40) begin @(negedge clk); n++; end
        #2 stall = 1'b1;
        n = 0;
        while (!tx_valid && n < 40) begin @(negedge clk); n++; end
        check_val("bst_txv_wait", {31'd0, tx_valid}, 32'd1);
        repeat (10) @(negedge clk);
        check_val("bst_stall_valid", {31'd0, tx_valid}, 32'd1);
        check_val("bst_stall_data", {24'd0, tx_data}, 32'h33);
        check_val("bst_stall_nolog", n_log, 4);
        check_val("bst_stall_noreq", {30'd0, rb_re, rb_we}, 32'd0);
        stall = 1'b0;
        wait_idle("bst_idle", 60);
        check_val("bst_ntx", n_tx, 5);
        check_val("bst_addrs", {8'd0, log_addr[2], log_addr[3], log_addr[4]}, 32'h909192);
        check_val("bst_data", {8'd0, tx_log[2], tx_log[3], tx_log[4]}, 32'h0A33C4);

        // burst wrapping through 0xFF
        ack_delay = 2;
        send_byte(8'h42);
        send_byte(8'hFE);
        send_byte(8'h03);
        wait_idle("wrap_idle", 80);
        check_val("wrap_addrs", {8'd0, log_addr[5], log_addr[6], log_addr[7]}, 32'hFEFF00);
        check_val("wrap_data", {8'd0, tx_log[5], tx_log[6], tx_log[7]}, 32'h112244);

        // zero-length burst
        base_log = n_log;
        base_tx  = n_tx;
        send_byte(8'h42);
        send_byte(8'h10);
        send_byte(8'h00);
        check_val("n0_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check_val("n0_noacc", n_log - base_log, 0);
        check_val("n0_notx", n_tx - base_tx, 0);

        // bus timeout: never acked
        ack_delay = 0;
        send_byte(8'h52);
        send_byte(8'h85);
        wait_idle("to_idle", 60);
        check_val("to_len", log_len[n_log-1], BUS_TO);
        check_val("to_rsp", {24'd0, tx_log[n_tx-1]}, 32'hFF);
        check_val("to_err", {31'd0, err_to}, 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("to_clr", {31'd0, err_to}, 32'd0);

        // ack in the last allowed cycle still succeeds
        ack_delay = BUS_TO;
        send_byte(8'h52);
        send_byte(8'h86);
        wait_idle("to8_idle", 60);
        check_val("to8_len", log_len[n_log-1], BUS_TO);
        check_val("to8_rsp", {24'd0, tx_log[n_tx-1]}, 32'h77);
        check_val("to8_err", {31'd0, err_to}, 32'd0);

        // unknown opcode ignored
        base_log = n_log;
        send_byte(8'h33);
        check_val("junk_busy", {31'd0, busy}, 32'd0);

        // frame timeout after a lone opcode
        base_tx = n_tx;
        send_byte(8'h52);
        repeat (FRAME_TO - 1) @(negedge clk);
        check_val("fto_still_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_val("fto_idle", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check_val("fto_noacc", n_log - base_log, 0);
        check_val("fto_notx", n_tx - base_tx, 0);

        // RX byte during BUS_WAIT is dropped and flagged
        ack_delay = 4;
        send_byte(8'h52);
        send_byte(8'h81);
        n = 0;
        while (!rb_re && n < 10) begin @(negedge clk); n++; end
        send_byte(8'h55);
        wait_idle("ovf_idle", 40);
        check_val("ovf_flag", {31'd0, err_ovf}, 32'd1);
        check_val("ovf_rsp", {24'd0, tx_log[n_tx-1]}, 32'h9C);
        check_val("ovf_nacc", n_log - base_log, 1);

        // reset during BUS_WAIT of the second burst read
        ack_delay = 2;
        base_tx = n_tx;
        send_byte(8'h42);
        send_byte(8'hA0);
        send_byte(8'h03);
        n = 0;
        while (n_tx == base_tx && n < 40) begin @(negedge clk); n++; end
        ack_delay = 0;
        n = 0;
        while (!rb_re && n < 10) begin @(negedge clk); n++; end
        check_val("mrst_in_wait", {31'd0, rb_re}, 32'd1);
        xinRESET = 1'b0;
        @(negedge clk);
        check_val("mrst_outs", {25'd0, tx_valid, rb_we, rb_re, busy, err_to, err_ovf, 1'b0},
                  32'd0);
        check_val("mrst_regs", {8'd0, tx_data, rb_addr, rb_wdata}, 32'h000000);
        xinRESET = 1'b1;
        base_tx = n_tx;
        repeat (5) @(negedge clk);
        check_val("mrst_no_rsp", n_tx - base_tx, 0);
        ack_delay = 1;
        send_byte(8'h52);
        send_byte(8'h81);
        wait_idle("post_idle", 40);
        check_val("post_addr", {24'd0, log_addr[n_log-1]}, 32'h81);
        check_val("post_rsp", {24'd0, tx_log[n_tx-1]}, 32'h9C);
        check_val("post_ntx", n_tx - base_tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
